// File: rtl/mpc_bank_req_arb.sv
`default_nettype none
// ============================================================================
// Module      : mpc_bank_req_arb
// Description : Round-robin bank request arbiter with per-channel credit
//               limits and a single registered output slot toward the HTU.
// Revision    : 1.0 - initial release
// ============================================================================
// u_bank_req packing, MSB first:
//   {channel_1hot_id[2:0], wbuffer_id, op[2:0], addr[31:0], wdata}
module mpc_bank_req_arb #(
    parameter int NumCh          = 3,
    parameter int MaxOutstanding = 4,
    parameter int WbufWidth      = 7,
    parameter int ClWordWidth    = 128,
    parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NumCh-1:0]                ch_req_valid,
    output logic [NumCh-1:0]                ch_req_ready,
    input  logic [3*NumCh-1:0]              ch_req_op,
    input  logic [32*NumCh-1:0]             ch_req_addr,
    input  logic [WbufWidth*NumCh-1:0]      ch_req_wbuf_id,
    input  logic [ClWordWidth*NumCh-1:0]    ch_req_wdata,
    input  logic [NumCh-1:0]                ch_done_valid,
    output logic                            u_bank_req_valid,
    input  logic                            u_bank_req_ready,
    output logic [3+WbufWidth+3+32+ClWordWidth-1:0] u_bank_req,
    output logic [CntWidth*NumCh-1:0]       ch_outstanding,
    output logic                            err_credit
);

    typedef struct packed {
        logic [2:0]             channel_1hot_id;
        logic [WbufWidth-1:0]   wbuffer_id;
        logic [2:0]             op;
        logic [31:0]            addr;
        logic [ClWordWidth-1:0] wdata;
    } bank_req_t;

    localparam logic [1:0] C_PTR_RESET = 2'd2;

    bank_req_t        r_req;
    logic             r_out_vld;
    logic [1:0]       r_last_ptr;
    logic             r_err;

    logic [NumCh-1:0] w_elig;
    logic [NumCh-1:0] w_grant;
    logic [NumCh-1:0] w_err_hit;
    logic [1:0]       w_idx;
    logic [1:0]       w_win;
    logic             w_found;
    logic             w_load_en;
    logic             w_accept;
    bank_req_t        w_load;

    assign w_load_en    = !r_out_vld || u_bank_req_ready;
    assign ch_req_ready = w_grant & {NumCh{w_load_en && !rst}};
    assign w_accept     = |ch_req_ready;

    // Search starts just after the last granted channel, wrapping mod NumCh.
    always_comb begin
        w_grant = '0;
        w_win   = r_last_ptr;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NumCh; k++) begin
            w_idx = 2'((int'(r_last_ptr) + k) % NumCh);
            if (!w_found && w_elig[w_idx]) begin
                w_found        = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_win          = w_idx;
            end
        end
    end

    always_comb begin
        w_load = '0;
        for (int i = 0; i < NumCh; i++) begin
            if (w_grant[i]) begin
                w_load.channel_1hot_id = 3'(1 << i);
                w_load.wbuffer_id      = ch_req_wbuf_id[i*WbufWidth +: WbufWidth];
                w_load.op              = ch_req_op[i*3 +: 3];
                w_load.addr            = ch_req_addr[i*32 +: 32];
                w_load.wdata           = ch_req_wdata[i*ClWordWidth +: ClWordWidth];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req      <= '0;
            r_out_vld  <= 1'b0;
            r_last_ptr <= C_PTR_RESET;
        end else if (w_accept) begin
            r_req      <= w_load;
            r_out_vld  <= 1'b1;
            r_last_ptr <= w_win;
        end else if (u_bank_req_ready) begin
            r_out_vld  <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NumCh; gi++) begin : g_ch
            logic [CntWidth-1:0] r_cnt;

            // Eligibility uses the registered count; a same-cycle done only helps next cycle.
            assign w_elig[gi]    = ch_req_valid[gi] && (r_cnt < CntWidth'(MaxOutstanding));
            assign w_err_hit[gi] = ch_done_valid[gi] && !ch_req_ready[gi] && (r_cnt == '0);
            assign ch_outstanding[gi*CntWidth +: CntWidth] = r_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (ch_req_ready[gi] && !ch_done_valid[gi]) begin
                    r_cnt <= r_cnt + CntWidth'(1);
                end else if (!ch_req_ready[gi] && ch_done_valid[gi] && (r_cnt != '0)) begin
                    r_cnt <= r_cnt - CntWidth'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (|w_err_hit) begin
            r_err <= 1'b1;
        end
    end

    assign u_bank_req_valid = r_out_vld;
    assign u_bank_req       = r_req;
    assign err_credit       = r_err;

endmodule
`default_nettype wire
